// File: rtl/stack_pkg.sv
// Shared definitions for the stack processor slice: status states,
// default geometry and the opcode constants used by the core.
package stack_pkg;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PART,
    S_FULL
  } stack_state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_DUP  = 4'h5;
  localparam logic [3:0] OP_SWAP = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/stack_regfile.sv
// Operand stack storage: one synchronous write port, asynchronous read,
// no reset on the array.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack serving the processor stack port: push/pop/replace strobes,
// registered pop data, state-decoded full/empty and sticky error flags.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   clear_err,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] SP_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] SP_ONE  = CW'(1);

  stack_state_t state, state_next;
  logic [CW-1:0] sp, sp_next;
  logic [AW-1:0] top_idx, wr_idx;
  logic [WIDTH-1:0] top_data;
  logic is_empty, is_full;
  logic do_push, do_pop, do_replace, set_ovf, set_udf, we;

  // sp == DEPTH wraps to index 0 in AW bits, so top_idx is still DEPTH-1
  assign top_idx = sp[AW-1:0] - AW'(1);

  always_comb begin
    is_empty   = (state == S_EMPTY);
    is_full    = (state == S_FULL);
    do_replace = push && pop && !is_empty;
    do_push    = push && (!pop || is_empty) && !is_full;
    do_pop     = pop && !push && !is_empty;
    set_ovf    = push && !pop && is_full;
    set_udf    = pop && is_empty;
    we         = resetN && (do_push || do_replace);
    wr_idx     = do_replace ? top_idx : sp[AW-1:0];

    sp_next = sp;
    if (do_push)     sp_next = sp + SP_ONE;
    else if (do_pop) sp_next = sp - SP_ONE;

    state_next = state;
    unique case (state)
      S_EMPTY: if (do_push) state_next = S_PART;
      S_PART: begin
        if (do_push && sp == SP_LAST)  state_next = S_FULL;
        else if (do_pop && sp == SP_ONE) state_next = S_EMPTY;
      end
      S_FULL:  if (do_pop) state_next = S_PART;
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) state <= S_EMPTY;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sp        <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp <= sp_next;
      if (do_pop || do_replace) data_out <= top_data;
      if (set_ovf)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (set_udf)        underflow <= 1'b1;
      else if (clear_err) underflow <= 1'b0;
    end
  end

  assign full  = (state == S_FULL);
  assign empty = (state == S_EMPTY);
  assign count = sp;

  stack_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk  (clk),
    .we   (we),
    .waddr(wr_idx),
    .wdata(data_in),
    .raddr(top_idx),
    .rdata(top_data)
  );

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit at DEPTH=4: directed scenarios plus
// randomized strobes against a queue-based LIFO reference.
module tb_stack_unit;
  import stack_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          resetN, push, pop, clear_err;
  logic [W-1:0]  data_in, data_out;
  logic          full, empty, overflow, underflow;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_ovf, m_udf;

  always #5 clk = ~clk;

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .resetN(resetN), .push(push), .pop(pop), .data_in(data_in),
    .clear_err(clear_err), .data_out(data_out), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // One clock with the given inputs; the reference LIFO advances on the same edge.
  task automatic drive(input logic r, input logic pu, input logic po,
                       input logic ce, input logic [W-1:0] d);
    logic so, su;
    resetN = r; push = pu; pop = po; clear_err = ce; data_in = d;
    @(posedge clk);
    so = 1'b0; su = 1'b0;
    if (!r) begin
      q.delete(); m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (pu && po) begin
        if (q.size() == 0) begin q.push_back(d); su = 1'b1; end
        else begin m_dout = q[q.size()-1]; q[q.size()-1] = d; end
      end else if (pu) begin
        if (q.size() == D) so = 1'b1; else q.push_back(d);
      end else if (po) begin
        if (q.size() == 0) su = 1'b1; else m_dout = q.pop_back();
      end
      if (so) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (su) m_udf = 1'b1; else if (ce) m_udf = 1'b0;
    end
    #1;
    resetN = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; data_in = '0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h00);
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_udf got=%b exp=0", underflow); end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, vals[i]);
      checks++; if (count !== CW'(i + 1)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    for (int i = 3; i >= 0; i--) begin
      drive(1, 0, 1, 0, 8'h00);
      checks++; if (data_out !== vals[i]) begin failures++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, data_out, vals[i]); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL drain_full got=%b exp=0", full); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    drive(0, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h11); drive(1, 1, 0, 0, 8'h22);
    drive(1, 1, 0, 0, 8'h33); drive(1, 1, 0, 0, 8'h44);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    drive(1, 1, 0, 0, 8'h55);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    drive(1, 0, 1, 0, 8'h00);
    checks++; if (data_out !== 8'h44) begin failures++; $display("FAIL ovf_pop got=%h exp=44", data_out); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    // replace while full must not flag overflow or change state
    drive(1, 1, 0, 0, 8'h66);
    drive(1, 0, 0, 1, 8'h00);
    drive(1, 1, 1, 0, 8'h77);
    checks++; if (data_out !== 8'h66) begin failures++; $display("FAIL full_replace_dout got=%h exp=66", data_out); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_replace_ovf got=%b exp=0", overflow); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_replace_full got=%b exp=1", full); end
  endtask

  task automatic test_replace();
    drive(0, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h11); drive(1, 1, 0, 0, 8'h22);
    drive(1, 1, 1, 0, 8'h99);
    checks++; if (data_out !== 8'h22) begin failures++; $display("FAIL replace_dout got=%h exp=22", data_out); end
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL replace_count got=%0d exp=2", count); end
    drive(1, 0, 1, 0, 8'h00);
    checks++; if (data_out !== 8'h99) begin failures++; $display("FAIL replace_pop got=%h exp=99", data_out); end
    drive(1, 0, 1, 0, 8'h00);
    checks++; if (data_out !== 8'h11) begin failures++; $display("FAIL replace_pop2 got=%h exp=11", data_out); end
  endtask

  task automatic test_underflow();
    drive(0, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'hAB); drive(1, 0, 1, 0, 8'h00);
    drive(1, 0, 1, 0, 8'h00);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_set got=%b exp=1", underflow); end
    checks++; if (data_out !== 8'hAB) begin failures++; $display("FAIL udf_hold got=%h exp=ab", data_out); end
    drive(1, 0, 0, 1, 8'h00);
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", underflow); end
    drive(1, 1, 1, 0, 8'h07);
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL udf_pushpop_count got=%0d exp=1", count); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_pushpop_flag got=%b exp=1", underflow); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL udf_pushpop_empty got=%b exp=0", empty); end
    drive(1, 0, 1, 0, 8'h00);
    checks++; if (data_out !== 8'h07) begin failures++; $display("FAIL udf_pushpop_data got=%h exp=07", data_out); end
    drive(1, 0, 1, 1, 8'h00);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_set_wins got=%b exp=1", underflow); end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h11); drive(1, 1, 0, 0, 8'h22);
    drive(1, 0, 1, 0, 8'h00);
    drive(0, 1, 0, 0, 8'h33);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL midrst_dout got=%h exp=00", data_out); end
    drive(1, 0, 1, 0, 8'h00);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL midrst_udf got=%b exp=1", underflow); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL midrst_pop_dout got=%h exp=00", data_out); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic pu, po, ce;
    drive(0, 0, 0, 0, 8'h00);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: op = OP_PUSH;
        1: op = OP_POP;
        2: op = OP_SWAP;
        default: op = OP_NOP;
      endcase
      pu = (op == OP_PUSH) || (op == OP_SWAP) || ($urandom_range(0, 9) == 0);
      po = (op == OP_POP)  || (op == OP_SWAP) || ($urandom_range(0, 9) == 0);
      ce = ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 99) != 0), pu, po, ce, W'($urandom));
      checks++; if (data_out !== m_dout) begin failures++; $display("FAIL rnd_dout n=%0d got=%h exp=%h", n, data_out, m_dout); end
      checks++; if (count !== CW'(q.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, q.size()); end
      checks++; if (full !== (q.size() == D)) begin failures++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, full, q.size() == D); end
      checks++; if (empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, empty, q.size() == 0); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflow, m_ovf); end
      checks++; if (underflow !== m_udf) begin failures++; $display("FAIL rnd_udf n=%0d got=%b exp=%b", n, underflow, m_udf); end
    end
  endtask

  initial begin
    resetN = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0; data_in = '0;
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_replace();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO stack that serves the multicycle stack processor's stack port, directly downstream of the processor core. It accepts single-cycle push/pop strobes, holds the operand stack in a register file, and returns popped data in a register. That data is valid the cycle after the pop strobe, which is when the processor's state machine samples it. It also reports full/empty status, occupancy, and sticky overflow/underflow errors for debug.

## Interface
- WIDTH, 8, data word width (matches processor datapath)
- DEPTH, 16, number of entries; power of two, ≥ 2
- clk  in  1  clock, all logic on rising edge
- resetN  in  1  reset, synchronous, active-low
- push  in  1  push strobe (processor stack_push)
- pop  in  1  pop strobe (processor stack_pop)
- data_in  in  WIDTH  word to push (processor stack_data_out)
- clear_err  in  1  synchronous clear of sticky error flags
- data_out  out  WIDTH  last popped word, registered (processor stack_data_in)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: push attempted while full without pop
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage is mem[0..DEPTH-1]. sp points to the next free slot, and count equals sp. The top of stack is mem[sp-1].
- Status state machine with states S_EMPTY, S_PART and S_FULL. full and empty are decoded from the state register, so there is no combinational path from push/pop.
- Per-edge action when resetN=1, decided by push, pop and state:
  - push only, not full: mem[sp] <= data_in; sp++.
  - push only, full: ignored; overflow <= 1; mem and sp unchanged.
  - pop only, not empty: data_out <= mem[sp-1]; sp--.
  - pop only, empty: ignored; underflow <= 1; data_out holds.
  - push+pop, not empty (including full): data_out <= mem[sp-1]; mem[sp-1] <= data_in; sp unchanged. This is a replace, and overflow is not flagged.
  - push+pop, empty: treated as push only (mem[0] <= data_in; sp=1); underflow <= 1.
  - neither: hold.
- State transitions:
  - S_EMPTY→S_PART on a net push.
  - S_PART→S_FULL when the net push makes sp==DEPTH.
  - S_PART→S_EMPTY when the net pop makes sp==0.
  - S_FULL→S_PART on a net pop.
  - Replace cycles never change state.
- count arithmetic: unsigned, width $clog2(DEPTH)+1. It never wraps, because the guarded cases above prevent it.
- clear_err=1 clears overflow/underflow on the edge. If an error condition occurs in the same cycle, the set wins.

## Timing
- Push latency: data is written on the strobe edge. A pop in the next cycle returns it.
- Pop latency: data_out is valid from the edge on which pop=1 is sampled, so the consumer reads it in the following cycle. It holds until the next successful pop or reset.
- full, empty and count update on the same edge as the sp change.
- Strobes are level-sampled per cycle. A strobe held for N cycles performs N operations.
- Reset (resetN=0 at an edge) forces:
  - sp=0, state=S_EMPTY
  - data_out=0, full=0, empty=1, count=0, overflow=0, underflow=0
- Reset overrides any concurrent push/pop. Mid-operation reset discards the stack contents logically; mem is not cleared.

## Structure
- Shared package stack_pkg holds:
  - the state enum (S_EMPTY, S_PART, S_FULL)
  - default WIDTH/DEPTH constants
  - the processor opcode constants already shared by the core, so the bench can drive both.
- Sub-module stack_regfile holds the memory: synchronous single write port, asynchronous read at index sp-1, no reset on the array. stack_unit owns sp, the FSM, data_out and the flags.

## Test plan
- Reset then idle → data_out=0, empty=1, full=0, count=0, errors 0.
- DEPTH=4: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → full=1, count=4. Then pop ×4 → data_out reads 0x44, 0x33, 0x22, 0x11 on successive cycles, ending with empty=1.
- Full stack, push 0x55 → overflow=1, count=4. A later pop returns 0x44.
- Stack holding {0x11, 0x22}, push+pop with data_in=0x99 → data_out=0x22, count=2. A following pop returns 0x99.
- Empty stack, pop → underflow=1, data_out unchanged. Then clear_err → underflow=0. Then simultaneous push 0x7 + pop → count=1, underflow=1.
- Push 0x11, 0x22, assert resetN=0 together with push → count=0, empty=1. Then pop → underflow=1, data_out=0.
